// File: rtl/data_memory_ws.sv
// data_memory_ws: byte-addressed, little-endian data memory with a
// req/ready/valid handshake and a fixed number of wait states per access.
// Byte, half and word loads/stores with sign/zero extension; misaligned,
// out-of-range and illegal-size requests complete with err_o and no write.
// Optional feature: define DMEM_ZERO_INIT_EN to zero the whole array after
// every reset release (INIT state, 4 bytes per cycle) before accepting work.
//
// Handshake: a request is accepted on a rising edge where req_i && ready_o;
// all request fields are captured on that edge. Each accepted request yields
// exactly one valid_o pulse, WAIT_CYCLES+1 cycles later; data_o/err_o are
// meaningful only while valid_o is high and are 0 otherwise.
module data_memory_ws #(
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic        err_o
);

    localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam logic [32:0] DEPTH33 = 33'(DEPTH_BYTES);
    // Counter value on which WAIT hands over to DONE (unused when WAIT_CYCLES is 0).
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_INIT = 2'd3
    } state_t;

`ifdef DMEM_ZERO_INIT_EN
    localparam state_t RESET_STATE = S_INIT;
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    logic [IW-1:0] init_ptr_q;
    logic          init_last;
`else
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t        state_q, state_d;
    logic          accept, commit;
    logic [3:0]    wait_cnt_q;

    // Request fields captured on the accept edge.
    logic          we_q, uns_q;
    logic [1:0]    size_q;
    logic [31:0]   addr_q, wdata_q;

    // Operands seen by the commit edge.
    logic          op_we, op_uns;
    logic [1:0]    op_size;
    logic [31:0]   op_addr, op_wdata;
    logic [2:0]    op_nbytes;
    logic          op_misalign, op_range_err, op_err;
    logic [32:0]   op_end;
    logic [32:0]   lane_sum;
    logic [AW-1:0] lane_idx [4];
    logic [31:0]   rd_word, ld_result;

    logic [31:0]   data_q;
    logic          err_q;

    logic [7:0]    mem [DEPTH_BYTES];

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= RESET_STATE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) state_d = S_DONE;
                    else                  state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) state_d = S_DONE;
                    else                  state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
`ifdef DMEM_ZERO_INIT_EN
                if (init_last) state_d = S_IDLE;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = RESET_STATE;
        endcase
    end

    // Handshake outputs and the accept/commit strobes.
    always_comb begin
        ready_o = (state_q == S_IDLE) || (state_q == S_DONE);
        valid_o = (state_q == S_DONE);
        accept  = req_i && ready_o;
        // The edge that enters DONE is the one that touches the array.
        commit  = ((state_q == S_WAIT) && (wait_cnt_q == WAIT_LAST)) ||
                  (accept && (WAIT_CYCLES == 0));
    end

    assign data_o = data_q;
    assign err_o  = err_q;

    // Wait-state counter, runs only while in WAIT.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wait_cnt_q <= 4'd0;
        end else if ((state_q == S_WAIT) && (wait_cnt_q != WAIT_LAST)) begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
        end else begin
            wait_cnt_q <= 4'd0;
        end
    end

    // Capture the request on the accept edge so later input changes are ignored.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            we_q    <= we_i;
            uns_q   <= unsigned_i;
            size_q  <= size_i;
            addr_q  <= addr_i;
            wdata_q <= data_i;
        end
    end

    // With no wait states the commit happens on the accept edge itself,
    // so the operands come straight from the ports.
    always_comb begin
        if (WAIT_CYCLES == 0) begin
            op_we    = we_i;
            op_uns   = unsigned_i;
            op_size  = size_i;
            op_addr  = addr_i;
            op_wdata = data_i;
        end else begin
            op_we    = we_q;
            op_uns   = uns_q;
            op_size  = size_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
        end
    end

    // Decode size, check alignment/range, and gather the four byte lanes.
    always_comb begin
        case (op_size)
            2'b00:   op_nbytes = 3'd1;
            2'b01:   op_nbytes = 3'd2;
            default: op_nbytes = 3'd4;
        endcase
        op_misalign  = ((op_size == 2'b01) && op_addr[0]) ||
                       ((op_size == 2'b10) && (op_addr[1:0] != 2'b00));
        // 33-bit sum so addresses near 2^32 cannot wrap back into range.
        op_end       = {1'b0, op_addr} + {30'd0, op_nbytes};
        op_range_err = (op_end > DEPTH33);
        op_err       = (op_size == 2'b11) || op_misalign || op_range_err;

        rd_word  = 32'd0;
        lane_sum = 33'd0;
        for (int k = 0; k < 4; k++) begin
            lane_sum = {1'b0, op_addr} + 33'(k);
            // Lanes beyond the array are parked at 0; they are never used
            // for an in-range access.
            lane_idx[k] = (lane_sum < DEPTH33) ? lane_sum[AW-1:0] : '0;
            rd_word[8*k +: 8] = mem[lane_idx[k]];
        end

        case (op_size)
            2'b00:   ld_result = {{24{~op_uns & rd_word[7]}}, rd_word[7:0]};
            2'b01:   ld_result = {{16{~op_uns & rd_word[15]}}, rd_word[15:0]};
            default: ld_result = rd_word;
        endcase
    end

    // Response registers: loaded on the commit edge, cleared on every other edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q <= 32'd0;
            err_q  <= 1'b0;
        end else if (commit) begin
            err_q  <= op_err;
            data_q <= (op_err || op_we) ? 32'd0 : ld_result;
        end else begin
            data_q <= 32'd0;
            err_q  <= 1'b0;
        end
    end

`ifdef DMEM_ZERO_INIT_EN
    // Sweep pointer for the zero-fill; restarts at 0 on every reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)               init_ptr_q <= '0;
        else if (state_q == S_INIT) init_ptr_q <= init_ptr_q + 1'b1;
    end

    assign init_last = (init_ptr_q == IW'(WORDS - 1));
`endif

    // Storage array: zero-fill during INIT, otherwise byte-lane stores on commit.
    always_ff @(posedge clk_i) begin
`ifdef DMEM_ZERO_INIT_EN
        if (state_q == S_INIT) begin
            for (int k = 0; k < 4; k++) begin
                mem[AW'({init_ptr_q, 2'b00}) + AW'(k)] <= 8'd0;
            end
        end else
`endif
        if (commit && op_we && !op_err) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < op_nbytes) mem[lane_idx[k]] <= op_wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ws.sv
// Bench for data_memory_ws: one instance with two wait states, one with none.
// Expected responses ({err, data}) are queued when a request is driven and
// checked by a per-instance monitor when valid_o pulses.
module tb_data_memory_ws;

    localparam int DEPTH = 1024;
    localparam int WORDS = DEPTH / 4;

`ifdef DMEM_ZERO_INIT_EN
    localparam int   INIT_CYCLES = WORDS;
    localparam logic RST_READY   = 1'b0;
`else
    localparam int   INIT_CYCLES = 0;
    localparam logic RST_READY   = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Two-wait-state instance.
    logic        req = 1'b0, we = 1'b0, uns = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        ready, valid, err;
    logic [31:0] rdata;

    // Zero-wait-state instance.
    logic        req0 = 1'b0, we0 = 1'b0, uns0 = 1'b0;
    logic [1:0]  size0 = 2'b00;
    logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
    logic        ready0, valid0, err0;
    logic [31:0] rdata0;

    data_memory_ws #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .we_i(we), .size_i(size),
        .unsigned_i(uns), .addr_i(addr), .data_i(wdata),
        .ready_o(ready), .valid_o(valid), .data_o(rdata), .err_o(err)
    );

    data_memory_ws #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req0), .we_i(we0), .size_i(size0),
        .unsigned_i(uns0), .addr_i(addr0), .data_i(wdata0),
        .ready_o(ready0), .valid_o(valid0), .data_o(rdata0), .err_o(err0)
    );

    logic [32:0] exp_q[$];
    logic [32:0] exp0_q[$];
    int n_checks = 0;
    int n_fail = 0;

    localparam logic [32:0] ST_OK = 33'd0;
    localparam logic [32:0] ERR   = {1'b1, 32'd0};

    // Monitor for the two-wait-state instance.
    always @(negedge clk) begin : mon
        logic [32:0] e;
        if (rst_n) begin
            n_checks++;
            if (valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL resp_unexpected: got err=%0b data=%h, required no response", err, rdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({err, rdata} !== e)
                        begin n_fail++; $display("FAIL resp: got err=%0b data=%h, required err=%0b data=%h", err, rdata, e[32], e[31:0]); end
                end
            end else if ({err, rdata} !== 33'd0) begin
                n_fail++;
                $display("FAIL idle_outputs: got err=%0b data=%h with valid=%b, required 0", err, rdata, valid);
            end
        end
    end

    // Monitor for the zero-wait-state instance.
    always @(negedge clk) begin : mon0
        logic [32:0] e;
        if (rst_n) begin
            n_checks++;
            if (valid0 === 1'b1) begin
                if (exp0_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL resp0_unexpected: got err=%0b data=%h, required no response", err0, rdata0);
                end else begin
                    e = exp0_q.pop_front();
                    if ({err0, rdata0} !== e)
                        begin n_fail++; $display("FAIL resp0: got err=%0b data=%h, required err=%0b data=%h", err0, rdata0, e[32], e[31:0]); end
                end
            end else if ({err0, rdata0} !== 33'd0) begin
                n_fail++;
                $display("FAIL idle_outputs0: got err=%0b data=%h with valid=%b, required 0", err0, rdata0, valid0);
            end
        end
    end

    // Drive one request into the two-wait-state instance; fields are
    // scrambled right after acceptance to show they were captured.
    task automatic drive_req(input logic w, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [32:0] e, input bit push);
        int guard = 0;
        @(negedge clk);
        while (ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        if (ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL ready_timeout: got ready=%b after %0d cycles, required 1", ready, guard);
        end
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; we = 1'($urandom); size = 2'($urandom_range(0, 3));
        uns = 1'($urandom); addr = $urandom; wdata = $urandom;
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || exp0_q.size() != 0) && g < 50) begin @(negedge clk); g++; end
        if (exp_q.size() != 0 || exp0_q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: got %0d/%0d responses outstanding, required 0", exp_q.size(), exp0_q.size());
            exp_q.delete(); exp0_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({valid, err, rdata} !== 34'd0 || {valid0, err0, rdata0} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b err=%b data=%h / valid0=%b err0=%b data0=%h, required all 0",
                     valid, err, rdata, valid0, err0, rdata0);
        end
        n_checks++;
        if (ready !== RST_READY || ready0 !== RST_READY) begin
            n_fail++;
            $display("FAIL reset_ready: got %b/%b, required %b", ready, ready0, RST_READY);
        end
        rst_n = 1'b1;
        while (ready !== 1'b1 && n < WORDS + 20) begin @(negedge clk); n++; end
        n_checks++;
        if (n != INIT_CYCLES || ready0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got %0d cycles to ready (ready0=%b), required %0d (ready0=1)", n, ready0, INIT_CYCLES);
        end
    endtask

    task automatic test_store_load();
        int lat;
        drive_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, ST_OK, 1'b1);
        lat = 1;
        while (valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        n_checks++;
        if (lat != 3 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL store_latency: got %0d cycles err=%b, required 3 cycles err=0", lat, err);
        end
        wait_drain();
        drive_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, {1'b0, 32'hDEADBEEF}, 1'b1);
        wait_drain();
    endtask

    task automatic test_extension();
        drive_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, {1'b0, 32'hFFFFFFDE}, 1'b1);
        drive_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, {1'b0, 32'h000000DE}, 1'b1);
        drive_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, {1'b0, 32'hFFFFBEEF}, 1'b1);
        drive_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, {1'b0, 32'h0000BEEF}, 1'b1);
        drive_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, {1'b0, 32'hFFFFFFBE}, 1'b1);
        drive_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, {1'b0, 32'h0000DEAD}, 1'b1);
        drive_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, {1'b0, 32'hFFFFDEAD}, 1'b1);
        wait_drain();
    endtask

    task automatic test_byte_store();
        drive_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF5A, ST_OK, 1'b1);
        drive_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, {1'b0, 32'hDEAD5AEF}, 1'b1);
        drive_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h01020304, ST_OK, 1'b1);
        drive_req(1'b1, 2'b01, 1'b0, 32'h32, 32'h7777ABCD, ST_OK, 1'b1);
        drive_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, {1'b0, 32'hABCD0304}, 1'b1);
        wait_drain();
    endtask

    task automatic test_errors();
        drive_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, ST_OK, 1'b1);
        drive_req(1'b1, 2'b10, 1'b0, DEPTH - 4, 32'h0BADF00D, ST_OK, 1'b1);
        // misaligned word load
        drive_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, ERR, 1'b1);
        drive_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, {1'b0, 32'hDEAD5AEF}, 1'b1);
        // misaligned half store
        drive_req(1'b1, 2'b01, 1'b0, 32'h21, 32'h0000FFFF, ERR, 1'b1);
        drive_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, {1'b0, 32'hCAFEF00D}, 1'b1);
        // word store straddling the end of the array
        drive_req(1'b1, 2'b10, 1'b0, DEPTH - 2, 32'h99999999, ERR, 1'b1);
        drive_req(1'b0, 2'b10, 1'b0, DEPTH - 4, 32'h0, {1'b0, 32'h0BADF00D}, 1'b1);
        // illegal size store
        drive_req(1'b1, 2'b11, 1'b0, 32'h20, 32'h55555555, ERR, 1'b1);
        drive_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, {1'b0, 32'hCAFEF00D}, 1'b1);
        drive_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, ERR, 1'b1);
        // range boundary: last byte/half legal, one past the end and wrap-around illegal
        drive_req(1'b0, 2'b00, 1'b1, DEPTH - 1, 32'h0, {1'b0, 32'h0000000B}, 1'b1);
        drive_req(1'b0, 2'b01, 1'b1, DEPTH - 2, 32'h0, {1'b0, 32'h00000BAD}, 1'b1);
        drive_req(1'b0, 2'b00, 1'b0, DEPTH, 32'h0, ERR, 1'b1);
        drive_req(1'b1, 2'b10, 1'b0, DEPTH, 32'h12345678, ERR, 1'b1);
        drive_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, ERR, 1'b1);
        drive_req(1'b0, 2'b10, 1'b0, DEPTH - 4, 32'h0, {1'b0, 32'h0BADF00D}, 1'b1);
        wait_drain();
    endtask

    task automatic test_random();
        logic [31:0] a, d, w;
        logic [7:0]  bd;
        int          b;
        for (int i = 0; i < 8; i++) begin
            a  = 32'h100 + 4 * $urandom_range(0, 63);
            d  = $urandom;
            b  = $urandom_range(0, 3);
            bd = 8'($urandom_range(0, 255));
            w  = d;
            w[8*b +: 8] = bd;
            drive_req(1'b1, 2'b10, 1'b0, a, d, ST_OK, 1'b1);
            drive_req(1'b0, 2'b10, 1'b0, a, 32'h0, {1'b0, d}, 1'b1);
            drive_req(1'b1, 2'b00, 1'b0, a + b, {24'hA5A5A5, bd}, ST_OK, 1'b1);
            drive_req(1'b0, 2'b10, 1'b0, a, 32'h0, {1'b0, w}, 1'b1);
            drive_req(1'b0, 2'b00, 1'b0, a + b, 32'h0, {1'b0, {{24{bd[7]}}, bd}}, 1'b1);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        for (int i = 0; i < 4; i++) vals[i] = $urandom;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            req0 = 1'b1; size0 = 2'b10; uns0 = 1'b0;
            addr0 = 32'h40 + 32'(4 * (i % 4));
            if (i < 4) begin
                we0 = 1'b1; wdata0 = vals[i]; exp0_q.push_back(ST_OK);
            end else begin
                we0 = 1'b0; wdata0 = $urandom; exp0_q.push_back({1'b0, vals[i-4]});
            end
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (ready0 !== 1'b1 || valid0 !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got ready0=%b valid0=%b, required 1/1", i, ready0, valid0);
            end
        end
        req0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (valid0 !== 1'b0 || ready0 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_end: got valid0=%b ready0=%b, required 0/1", valid0, ready0);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_op();
        int n = 0;
        // Accepted store, then reset while it is still waiting: no response expected.
        drive_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, ST_OK, 1'b0);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (valid !== 1'b0 || ready !== RST_READY) begin
                n_fail++;
                $display("FAIL reset_mid_op: got valid=%b ready=%b, required 0/%b", valid, ready, RST_READY);
            end
        end
        rst_n = 1'b1;
        while (ready !== 1'b1 && n < WORDS + 20) begin @(negedge clk); n++; end
        n_checks++;
        if (n != INIT_CYCLES) begin
            n_fail++;
            $display("FAIL reset_mid_op_release: got %0d cycles to ready, required %0d", n, INIT_CYCLES);
        end
        repeat (5) @(negedge clk);
`ifdef DMEM_ZERO_INIT_EN
        drive_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, {1'b0, 32'h00000000}, 1'b1);
`else
        drive_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, {1'b0, 32'hCAFEF00D}, 1'b1);
`endif
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_extension();
        test_byte_store();
        test_errors();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
